// File: rtl/encoder_pkg.sv
// Shared types and helpers for the encoder position display path:
// conversion states, 7-segment codes and the double-dabble nibble adjust.
package encoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] nibble);
    add3 = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: re-converts whenever the input differs
// from the last captured value, one bit per clock.
module bin2bcd_seq
  import encoder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      pos,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  conv_state_t               state, state_next;
  logic [WIDTH-1:0]          last_pos;
  logic [WIDTH-1:0]          shreg;
  logic [4*DIGITS-1:0]       acc;
  logic [4*DIGITS-1:0]       acc_adj;
  logic [4*DIGITS+WIDTH-1:0] shifted;
  logic [CNT_W-1:0]          cnt;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pos != last_pos) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(WIDTH - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      acc_adj[4*i +: 4] = add3(acc[4*i +: 4]);
    end
    shifted = {acc_adj, shreg} << 1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_pos <= '0;
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (pos != last_pos) begin
            shreg    <= pos;
            last_pos <= pos;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          {acc, shreg} <= shifted;
          cnt          <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The accumulator is stable throughout DONE, so the consumer latches it then.
  assign bcd   = acc;
  assign valid = (state == DONE);

endmodule

// File: rtl/pos_display.sv
// Encoder position to multiplexed common-anode 7-segment display with
// leading-zero blanking.
module pos_display
  import encoder_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int SCAN_HZ     = 1000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  pos,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy
);

  localparam int SCAN_DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_chk_digits
    $error("pos_display: DIGITS too small for WIDTH");
  end
  if (SCAN_DIV < 2) begin : g_chk_div
    $error("pos_display: SCAN_DIV must be at least 2");
  end

  logic [4*DIGITS-1:0] conv_bcd;
  logic                conv_valid;
  logic [4*DIGITS-1:0] disp_bcd;
  logic [PRE_W-1:0]    prescale;
  logic [IDX_W-1:0]    index;
  logic [DIGITS-1:0]   blank;
  logic                zero_above;
  logic [3:0]          cur_digit;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clock   (clock),
    .reset_n (reset_n),
    .pos     (pos),
    .bcd     (conv_bcd),
    .valid   (conv_valid),
    .busy    (busy)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_bcd <= '0;
    end else if (conv_valid) begin
      disp_bcd <= conv_bcd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      index    <= '0;
    end else if (prescale == PRE_W'(SCAN_DIV - 1)) begin
      prescale <= '0;
      index    <= (index == IDX_W'(DIGITS - 1)) ? '0 : index + IDX_W'(1);
    end else begin
      prescale <= prescale + PRE_W'(1);
    end
  end

  // A digit blanks only when it and every digit above it are zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (disp_bcd[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
    cur_digit = disp_bcd[4*index +: 4];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      an  <= ~(DIGITS'(1) << index);
      seg <= blank[index] ? SEG_BLANK : seg7(cur_digit);
    end
  end

endmodule
